// File: rtl/alu_pkg.sv
// Shared opcode and issuer FSM definitions for the ALU command front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 2'b00;
    localparam alu_op_t ALU_OP_SUB = 2'b01;
    localparam alu_op_t ALU_OP_AND = 2'b10;
    localparam alu_op_t ALU_OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } issuer_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with push/pop, full/empty flags and occupancy count.
// Latency: an entry pushed at one edge is presented on pop_dat from the next cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage: only accepted pushes write; contents need no reset since
    // nothing is read while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues each with a one-cycle en pulse and presents the tagged result.
// Latency: push edge to res_valid is 3+ALU_LAT cycles from idle; one result per ALU_LAT+2 cycles.
// Backpressure: cmd_ready drops when the FIFO is full; a result is held stable until res_ready.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W       = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  alu_op_t      cmd_op,
    output logic [W-1:0] alu_inA,
    output logic [W-1:0] alu_inB,
    output alu_op_t      alu_op,
    output logic         alu_en,
    input  logic [W-1:0] alu_ans,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output alu_op_t      res_op,
    output logic         busy
);

    localparam int FW = 2 * W + 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LW-1:0] WAIT_LAST = LW'(ALU_LAT - 1);

    issuer_state_t state;
    logic [LW-1:0] wait_cnt;
    logic          has_cmd_q;
    logic          issue_go;
    logic [FW-1:0] fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_valid),
        .push_dat ({cmd_a, cmd_b, cmd_op}),
        .pop      (issue_go),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state != IDLE);

    // From IDLE the issue decision uses last cycle's occupancy, giving a fresh
    // command one settle cycle; from HOLD the live flag keeps back-to-back issue.
    // has_cmd_q cannot be stale in IDLE: no pop happens while idle or on HOLD->IDLE.
    assign issue_go = ((state == IDLE) && has_cmd_q && !fifo_empty) ||
                      ((state == HOLD) && res_ready && !fifo_empty);

    // Issuer FSM with registered ALU drive and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            has_cmd_q <= 1'b0;
            alu_en    <= 1'b0;
            alu_inA   <= '0;
            alu_inB   <= '0;
            alu_op    <= ALU_OP_ADD;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= ALU_OP_ADD;
        end else begin
            has_cmd_q <= !fifo_empty;
            alu_en    <= issue_go;
            if (issue_go) begin
                {alu_inA, alu_inB, alu_op} <= fifo_dat;
            end
            case (state)
                IDLE: begin
                    if (issue_go) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        res_data  <= alu_ans;
                        res_op    <= alu_op;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + LW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= issue_go ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU and result scoreboard.
// Latency: checks issue/result timing from the push edge.
// Backpressure: exercises full FIFO and held results.
module tb_alu_cmd_issuer;

    localparam int W       = 4;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;
    localparam int RV      = 4 + 3 * W + 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [1:0]   cmd_op = '0;
    logic [W-1:0] alu_inA;
    logic [W-1:0] alu_inB;
    logic [1:0]   alu_op;
    logic         alu_en;
    logic [W-1:0] alu_ans;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic [1:0]   res_op;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    int           got_cyc[$];
    int           cyc_n = 0;
    int           en_total = 0;
    int           en_consec = 0;
    int           stab_viol = 0;
    logic         prev_en = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W+1:0] prev_res = '0;
    logic [W-1:0] alu_pipe [ALU_LAT];

    always #5 clk = ~clk;

    alu_cmd_issuer #(.W(W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_op    (alu_op),
        .alu_en    (alu_en),
        .alu_ans   (alu_ans),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .busy      (busy)
    );

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + (1 << W);
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return W'(r % (1 << W));
    endfunction

    // Behavioural ALU: result registered on en, delayed ALU_LAT cycles.
    initial for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] = '0;
    always @(posedge clk) begin
        if (alu_en) alu_pipe[0] <= ref_alu(alu_inA, alu_inB, alu_op);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_ans = alu_pipe[ALU_LAT-1];

    // Observer at the falling edge: records handshakes, en pulses and hold stability.
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (prev_hold && (res_valid !== 1'b1 || {res_op, res_data} !== prev_res))
            stab_viol = stab_viol + 1;
        if (!reset) begin
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                got_q.push_back({res_op, res_data});
                got_cyc.push_back(cyc_n);
            end
            if (alu_en === 1'b1) en_total = en_total + 1;
            if (alu_en === 1'b1 && prev_en === 1'b1) en_consec = en_consec + 1;
        end
        prev_en   = alu_en;
        prev_hold = (res_valid === 1'b1) && (res_ready === 1'b0) && !reset;
        prev_res  = {res_op, res_data};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command (called just after a rising edge); returns once accepted.
    task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, output bit ok);
        ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                exp_q.push_back({op, ref_alu(a, b, op)});
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (got_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_sb;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset;
        logic [RV-1:0] want;
        want = {1'b1, 1'b0, 1'b0, 1'b0, {(RV-4){1'b0}}};
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, alu_en, res_valid, busy, alu_inA, alu_inB, alu_op, res_data, res_op} !== want) begin
            n_fail++;
            $display("FAIL reset_values: got %b required %b",
                     {cmd_ready, alu_en, res_valid, busy, alu_inA, alu_inB, alu_op, res_data, res_op}, want);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int en_cyc = -1;
        int en_cnt = 0;
        int rv_cyc = -1;
        bit ok;
        clear_sb();
        res_ready = 1'b0;
        cmd_a = 4'b1011; cmd_b = 4'b0010; cmd_op = 2'b00; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (alu_en === 1'b1) begin en_cnt++; en_cyc = k; end
            if (res_valid === 1'b1 && rv_cyc < 0) rv_cyc = k;
        end
        n_cmp++;
        if (en_cnt != 1) begin n_fail++; $display("FAIL single_en_count: got %0d required 1", en_cnt); end
        n_cmp++;
        if (en_cyc != 2) begin n_fail++; $display("FAIL single_en_cycle: got %0d required 2", en_cyc); end
        n_cmp++;
        if (rv_cyc != 3 + ALU_LAT) begin
            n_fail++; $display("FAIL single_res_latency: got %0d required %0d", rv_cyc, 3 + ALU_LAT);
        end
        n_cmp++;
        if ({res_op, res_data} !== 6'b00_1101) begin
            n_fail++; $display("FAIL single_result: got %b required %b", {res_op, res_data}, 6'b00_1101);
        end
        n_cmp++;
        if ({alu_inA, alu_inB, alu_op} !== 10'b1011_0010_00) begin
            n_fail++; $display("FAIL single_operands_held: got %b required %b", {alu_inA, alu_inB, alu_op}, 10'b1011_0010_00);
        end
        tick();
        res_ready = 1'b1;
        wait_results(1, ok);
        n_cmp++;
        if (!ok || got_q[0] !== 6'b00_1101) begin
            n_fail++; $display("FAIL single_drain: got %0d results required 1 of 0x0d", got_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [W+1:0] want [3];
        want[0] = 6'b01_1001; want[1] = 6'b10_0010; want[2] = 6'b11_1011;
        clear_sb();
        res_ready = 1'b1;
        push_cmd(4'b1011, 4'b0010, 2'b01, ok);
        push_cmd(4'b1011, 4'b0010, 2'b10, ok);
        push_cmd(4'b1011, 4'b0010, 2'b11, ok);
        wait_results(3, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL burst_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want[i]) begin
                n_fail++; $display("FAIL burst_result[%0d]: got %b required %b", i, got_q[i], want[i]);
            end
        end
        for (int i = 1; i < 3 && i < got_cyc.size(); i++) begin
            n_cmp++;
            if (got_cyc[i] - got_cyc[i-1] != ALU_LAT + 2) begin
                n_fail++; $display("FAIL burst_spacing[%0d]: got %0d required %0d", i, got_cyc[i] - got_cyc[i-1], ALU_LAT + 2);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_full;
        int accepted = 0;
        int first_full = -1;
        bit acc;
        bit ok;
        clear_sb();
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (accepted < 6 && !cmd_valid) begin
                cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
            end
            if (c == 15) res_ready = 1'b1;
            @(negedge clk);
            acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
            if (acc) begin
                exp_q.push_back({cmd_op, ref_alu(cmd_a, cmd_b, cmd_op)});
                accepted++;
            end
            if (cmd_ready !== 1'b1 && first_full < 0) first_full = accepted;
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (first_full != DEPTH + 1) begin
            n_fail++; $display("FAIL full_ready_drop: dropped after %0d pushes required %0d", first_full, DEPTH + 1);
        end
        wait_results(6, ok);
        n_cmp++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            n_fail++; $display("FAIL full_count: got %0d results required 6 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_order[%0d]: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure;
        bit ok;
        bit found = 1'b0;
        int bad = 0;
        clear_sb();
        res_ready = 1'b0;
        push_cmd(4'b0111, 4'b0110, 2'b00, ok);
        push_cmd(4'b0101, 4'b1100, 2'b01, ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin found = 1'b1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL bp_res_valid: got 0 required 1 within 20 cycles"); end
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (res_valid !== 1'b1 || alu_en !== 1'b0 || {res_op, res_data} !== exp_q[0]) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles required 0 (res %b want %b)", bad, {res_op, res_data}, exp_q[0]);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (alu_en !== 1'b1) begin n_fail++; $display("FAIL bp_issue_after_release: alu_en got %b required 1", alu_en); end
        tick();
        res_ready = 1'b1;
        wait_results(2, ok);
        n_cmp++;
        if (!ok || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_fail++; $display("FAIL bp_drain: got %0d results required 2 in order", got_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_wrap;
        int n = 3 * DEPTH;
        int sent = 0;
        bit acc = 1'b0;
        bit ok;
        clear_sb();
        cmd_valid = 1'b0;
        for (int c = 0; c < 3000 && (sent < n || got_q.size() < n); c++) begin
            if (acc) cmd_valid = 1'b0;
            if (!cmd_valid && sent < n && $urandom_range(0, 3) != 0) begin
                cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
            end
            res_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
            if (acc) begin
                exp_q.push_back({cmd_op, ref_alu(cmd_a, cmd_b, cmd_op)});
                sent++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_results(n, ok);
        n_cmp++;
        if (got_q.size() != n) begin n_fail++; $display("FAIL wrap_count: got %0d required %0d", got_q.size(), n); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL wrap_result[%0d]: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (en_consec != 0) begin n_fail++; $display("FAIL en_consecutive: got %0d required 0", en_consec); end
        n_cmp++;
        if (stab_viol != 0) begin n_fail++; $display("FAIL hold_stability: got %0d violations required 0", stab_viol); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        bit found = 1'b0;
        int en_before;
        logic [RV-1:0] want;
        want = {1'b1, 1'b0, 1'b0, 1'b0, {(RV-4){1'b0}}};
        clear_sb();
        res_ready = 1'b1;
        push_cmd(4'b1111, 4'b0001, 2'b00, ok);
        push_cmd(4'b0011, 4'b0101, 2'b10, ok);
        push_cmd(4'b1000, 4'b0001, 2'b11, ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (alu_en === 1'b1) begin found = 1'b1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL rst_issue_seen: got 0 required 1"); end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, alu_en, res_valid, busy, alu_inA, alu_inB, alu_op, res_data, res_op} !== want) begin
            n_fail++;
            $display("FAIL rst_mid_wait_values: got %b required %b",
                     {cmd_ready, alu_en, res_valid, busy, alu_inA, alu_inB, alu_op, res_data, res_op}, want);
        end
        tick();
        reset = 1'b0;
        en_before = en_total;
        repeat (20) tick();
        n_cmp++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_stale_result: got %0d results required 0", got_q.size()); end
        n_cmp++;
        if (en_total != en_before) begin
            n_fail++; $display("FAIL rst_stale_issue: got %0d en pulses required 0", en_total - en_before);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_backpressure();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
